reg_bus_fabric: RTL and testbench
=================================

// Module: reg_bus_fabric
// PURPOSE
//  Parametrised register-bus interconnect between the SPI register master and NUM_SLV register slaves.
//  Decodes set_wr/set_rd addresses into per-slave address windows and registers the strobes.
//  Returns read data using an explicit ack handshake, priority arbitration, a timeout and error flags.
//  Also generates the stretched power-on system reset for all downstream logic.
// PARAMETERS
//  NUM_SLV     4             number of slave channels (1..8)
//  AW          16            address width
//  DW          16            data width
//  SLV_BASE    {NUM_SLV*AW}  packed base addresses; slave i = bits [i*AW +: AW]
//  SLV_MASK    {NUM_SLV*AW}  packed masks; hit_i = ((addr & MASK_i) == BASE_i)
//  RD_TIMEOUT  16            cycles to wait for slv_rd_ack before aborting (>=2)
//  RST_CYCLES  24'hFFFFFF    sys_reset_o hold after reset_i release (use 8 in simulation)
//  ERR_DATA    16'hDEAD      data returned on timeout or unmapped read
// PORTS
//  clk_i        in   1          system clock
//  reset_i      in   1          asynchronous, active-high reset
//  sys_reset_o  out  1          stretched synchronous reset for downstream blocks
//  set_wr_en    in   1          host write strobe (1 cycle)
//  set_wr_addr  in   AW         host write address
//  set_wr_data  in   DW         host write data
//  set_rd_en    in   1          host read strobe (1 cycle)
//  set_rd_addr  in   AW         host read address
//  set_rd_data  out  DW         read response data, valid with set_rd_vld
//  set_rd_vld   out  1          1-cycle read response pulse
//  slv_wr_en    out  NUM_SLV    per-slave write strobe
//  slv_rd_en    out  NUM_SLV    per-slave read strobe
//  slv_addr     out  AW         shared registered address
//  slv_wr_data  out  DW         shared registered write data
//  slv_rd_data  in   NUM_SLV*DW per-slave read data, slave i at [i*DW +: DW]
//  slv_rd_ack   in   NUM_SLV    per-slave read data valid
//  err_flags    out  3          sticky {rd_overrun, unmapped, timeout}; cleared by write to 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0 except sys_reset_o=1. FSM=IDLE, counters=0.
//  - Reset generator: 24-bit counter starts at reset_i release and saturates at RST_CYCLES.
//    sys_reset_o=1 until saturation, then 0 (registered). Re-asserting reset_i restarts the counter.
//  - Write path, latency 1: set_wr_en -> next cycle slv_wr_en[i]=1 for every hit i
//    (overlapping windows: all hits); slv_addr and slv_wr_data carry the registered values.
//    No hit -> no strobe, unmapped flag set. Writes are accepted in every FSM state.
//  - Read FSM:
//    - IDLE: on set_rd_en with a hit -> slv_rd_en[lowest hit]=1 next cycle, go to WAIT, timer=0.
//      On set_rd_en with no hit -> set_rd_vld=1 and data=ERR_DATA next cycle, set unmapped, stay IDLE.
//    - WAIT: timer increments each cycle.
//      - slv_rd_ack from the selected slave -> next cycle set_rd_vld=1 with data=that slave's
//        slv_rd_data, go to IDLE. Acks from non-selected slaves are ignored.
//      - timer==RD_TIMEOUT-1 with no ack -> next cycle set_rd_vld=1, data=ERR_DATA,
//        set timeout flag, go to IDLE.
//      - Ack and timeout in the same cycle -> ack wins.
//    - set_rd_en while in WAIT -> request dropped, rd_overrun set, no response generated.
//  - Write and read in the same cycle: both are processed independently; slv_addr carries the write address.
//    The read address is held internally and slv_addr switches to the read address only when no write strobe is present.
//  - Read of address 16'hFFFF (reserved) -> data {13'b0, err_flags}, latency 1, no slave access.
//  - slv_* outputs and set_rd_vld are forced to 0 while sys_reset_o=1; host strobes are ignored during that time.
// STRUCTURE
//  - Shared package reg_bus_pkg: FSM state encodings, ERR_DATA, reserved address 16'hFFFF, err bit indices.
//  - One sub-module: por_stretch (counter-based reset generator, parameter RST_CYCLES).
//  - Decode and priority encoding are generated loops in the top block.
// TESTING
//  1. Release reset_i with RST_CYCLES=8 -> sys_reset_o falls exactly 8 cycles later; reset_i pulse mid-count restarts the count.
//  2. Write 0x1234 to 0x0102 (slave 1 BASE=0x0100, MASK=0xFF00) -> slv_wr_en=4'b0010 for 1 cycle with slv_wr_data=0x1234.
//  3. Read 0x0005 on slave 0; slave acks 3 cycles later with 0xBEEF -> set_rd_vld pulse with 0xBEEF.
//  4. Read slave 2 with no ack, RD_TIMEOUT=16 -> vld with 0xDEAD 16 cycles after slv_rd_en; read 0xFFFF -> 0x0001.
//  5. Read unmapped 0x7000 -> 0xDEAD after 1 cycle, unmapped flag set. Second read during WAIT -> dropped, rd_overrun set.
//  6. Assert reset_i during WAIT -> outputs 0 immediately, FSM=IDLE, and a late ack produces no response.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared types and constants
// for the register-bus fabric.
package reg_bus_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rdState_e;

  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;
  localparam logic [15:0] RSV_ADDR     = 16'hFFFF;

  localparam int ERR_TMO = 0;
  localparam int ERR_UNM = 1;
  localparam int ERR_OVR = 2;

endpackage

// File: rtl/por_stretch.sv
// por_stretch: holds the downstream reset for
// RST_CYCLES clocks after reset_i is released.
module por_stretch #(
  parameter logic [23:0] RST_CYCLES = 24'hFFFFFF
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic sysReset
);

  logic [23:0] cnt;

  // saturating release counter; reset drops on the saturating edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt      <= '0;
      sysReset <= 1'b1;
    end else if (cnt != RST_CYCLES) begin
      cnt      <= cnt + 24'd1;
      sysReset <= (cnt != RST_CYCLES - 24'd1);
    end else begin
      sysReset <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_bus_fabric.sv
// reg_bus_fabric: host-to-slave register bus with
// window decode, read ack/timeout FSM and error flags.
module reg_bus_fabric
  import reg_bus_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE =
    {16'h0200, 16'h0200, 16'h0100, 16'h0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK =
    {16'hFE00, 16'hFF00, 16'hFF00, 16'hFF00},
  parameter int RD_TIMEOUT = 16,
  parameter logic [23:0] RST_CYCLES = 24'hFFFFFF,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic                  sys_reset_o,
  input  logic                  set_wr_en,
  input  logic [AW-1:0]         set_wr_addr,
  input  logic [DW-1:0]         set_wr_data,
  input  logic                  set_rd_en,
  input  logic [AW-1:0]         set_rd_addr,
  output logic [DW-1:0]         set_rd_data,
  output logic                  set_rd_vld,
  output logic [NUM_SLV-1:0]    slv_wr_en,
  output logic [NUM_SLV-1:0]    slv_rd_en,
  output logic [AW-1:0]         slv_addr,
  output logic [DW-1:0]         slv_wr_data,
  input  logic [NUM_SLV*DW-1:0] slv_rd_data,
  input  logic [NUM_SLV-1:0]    slv_rd_ack,
  output logic [2:0]            err_flags
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic sysReset, act, wrEn, rdEn;
  logic wrRsv, rdRsv, launch;
  logic [NUM_SLV-1:0] wrHit, rdHit;
  rdState_e state, stateN;
  logic [TW-1:0] timer, timerN;
  logic [SW-1:0] sel, selN, lowSel;
  logic [NUM_SLV-1:0] slvWrEnQ, slvRdEnQ, slvRdEnN;
  logic [AW-1:0] slvAddrQ, rdAddrQ;
  logic [DW-1:0] slvWrDataQ, rdDataQ, rdDataN, selData;
  logic rdVldQ, rdVldN, selAck;
  logic [2:0] errQ, errSet;

  por_stretch #(.RST_CYCLES(RST_CYCLES)) uPor (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sysReset (sysReset)
  );

  assign sys_reset_o = sysReset;
  assign act  = ~sysReset;
  assign wrEn = set_wr_en & act;
  assign rdEn = set_rd_en & act;
  assign wrRsv = (set_wr_addr == AW'(RSV_ADDR));
  assign rdRsv = (set_rd_addr == AW'(RSV_ADDR));

  for (genvar i = 0; i < NUM_SLV; i++) begin : gDec
    assign wrHit[i] = ~wrRsv &
      ((set_wr_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
    assign rdHit[i] = ~rdRsv &
      ((set_rd_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
  end

  // lowest-index read hit and selected-slave response mux
  always_comb begin
    lowSel  = '0;
    selData = '0;
    selAck  = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (rdHit[i]) lowSel = SW'(i);
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel == SW'(i)) begin
        selAck  = slv_rd_ack[i];
        selData = slv_rd_data[i*DW +: DW];
      end
    end
  end

  // read FSM next state, response and error-flag events
  always_comb begin
    stateN   = state;
    timerN   = timer;
    selN     = sel;
    rdVldN   = 1'b0;
    rdDataN  = rdDataQ;
    slvRdEnN = '0;
    launch   = 1'b0;
    errSet   = '0;
    if (wrEn && !wrRsv && wrHit == '0) errSet[ERR_UNM] = 1'b1;
    unique case (state)
      RD_IDLE: begin
        if (rdEn) begin
          if (rdRsv) begin
            rdVldN  = 1'b1;
            rdDataN = {{(DW-3){1'b0}}, errQ};
          end else if (|rdHit) begin
            launch           = 1'b1;
            slvRdEnN[lowSel] = 1'b1;
            selN             = lowSel;
            timerN           = '0;
            stateN           = RD_WAIT;
          end else begin
            rdVldN          = 1'b1;
            rdDataN         = ERR_DATA;
            errSet[ERR_UNM] = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (rdEn) errSet[ERR_OVR] = 1'b1;
        if (selAck) begin
          rdVldN  = 1'b1;
          rdDataN = selData;
          stateN  = RD_IDLE;
        end else if (timer == TW'(RD_TIMEOUT - 1)) begin
          rdVldN          = 1'b1;
          rdDataN         = ERR_DATA;
          errSet[ERR_TMO] = 1'b1;
          stateN          = RD_IDLE;
        end else begin
          timerN = timer + 1'b1;
        end
      end
      default: stateN = RD_IDLE;
    endcase
  end

  // read FSM registers, response and sticky error flags
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= RD_IDLE;
      timer    <= '0;
      sel      <= '0;
      rdVldQ   <= 1'b0;
      rdDataQ  <= '0;
      slvRdEnQ <= '0;
      rdAddrQ  <= '0;
      errQ     <= '0;
    end else begin
      state    <= stateN;
      timer    <= timerN;
      sel      <= selN;
      rdVldQ   <= rdVldN;
      rdDataQ  <= rdDataN;
      slvRdEnQ <= slvRdEnN;
      if (launch) rdAddrQ <= set_rd_addr;
      errQ <= ((wrEn && wrRsv) ? 3'b000 : errQ) | errSet;
    end
  end

  // write strobes and shared address/data; a write owns slv_addr
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slvWrEnQ   <= '0;
      slvWrDataQ <= '0;
      slvAddrQ   <= '0;
    end else begin
      slvWrEnQ <= wrEn ? wrHit : '0;
      if (wrEn) slvWrDataQ <= set_wr_data;
      if (wrEn) slvAddrQ <= set_wr_addr;
      else if (launch) slvAddrQ <= set_rd_addr;
      else if (state == RD_WAIT) slvAddrQ <= rdAddrQ;
    end
  end

  assign slv_wr_en   = act ? slvWrEnQ : '0;
  assign slv_rd_en   = act ? slvRdEnQ : '0;
  assign slv_addr    = act ? slvAddrQ : '0;
  assign slv_wr_data = act ? slvWrDataQ : '0;
  assign set_rd_vld  = rdVldQ & act;
  assign set_rd_data = rdDataQ;
  assign err_flags   = errQ;

endmodule

// File: tb/tb_reg_bus_fabric.sv
// tb_reg_bus_fabric: random transactions against a
// window-range reference model of the register fabric.
module tb_reg_bus_fabric;

  localparam int NS = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic sys_reset_o;
  logic set_wr_en = 1'b0;
  logic [AW-1:0] set_wr_addr = '0;
  logic [DW-1:0] set_wr_data = '0;
  logic set_rd_en = 1'b0;
  logic [AW-1:0] set_rd_addr = '0;
  logic [DW-1:0] set_rd_data;
  logic set_rd_vld;
  logic [NS-1:0] slv_wr_en, slv_rd_en;
  logic [AW-1:0] slv_addr;
  logic [DW-1:0] slv_wr_data;
  logic [NS*DW-1:0] slv_rd_data = '0;
  logic [NS-1:0] slv_rd_ack = '0;
  logic [2:0] err_flags;

  reg_bus_fabric #(
    .NUM_SLV(NS), .AW(AW), .DW(DW),
    .SLV_BASE({16'h0200, 16'h0200, 16'h0100, 16'h0000}),
    .SLV_MASK({16'hFE00, 16'hFF00, 16'hFF00, 16'hFF00}),
    .RD_TIMEOUT(16), .RST_CYCLES(24'd8), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .sys_reset_o(sys_reset_o),
    .set_wr_en(set_wr_en), .set_wr_addr(set_wr_addr),
    .set_wr_data(set_wr_data), .set_rd_en(set_rd_en),
    .set_rd_addr(set_rd_addr), .set_rd_data(set_rd_data),
    .set_rd_vld(set_rd_vld), .slv_wr_en(slv_wr_en),
    .slv_rd_en(slv_rd_en), .slv_addr(slv_addr),
    .slv_wr_data(slv_wr_data), .slv_rd_data(slv_rd_data),
    .slv_rd_ack(slv_rd_ack), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;
  logic [2:0] mFlags = '0;
  logic [15:0] mLo[NS] = '{16'h0000, 16'h0100, 16'h0200, 16'h0200};
  logic [15:0] mHi[NS] = '{16'h00FF, 16'h01FF, 16'h02FF, 16'h03FF};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS-1:0] hits(input logic [15:0] a);
    hits = '0;
    if (a != 16'hFFFF)
      for (int i = 0; i < NS; i++)
        if (a >= mLo[i] && a <= mHi[i]) hits[i] = 1'b1;
  endfunction

  function automatic int first(input logic [NS-1:0] h);
    first = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (h[i]) first = i;
  endfunction

  function automatic logic [15:0] randAddr;
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 6)
      0: randAddr = {8'h00, r[7:0]};
      1: randAddr = {8'h01, r[7:0]};
      2: randAddr = {8'h02, r[7:0]};
      3: randAddr = {8'h03, r[7:0]};
      4: randAddr = 16'h4000 | {2'b00, r[13:0]};
      default: randAddr = 16'hFFFF;
    endcase
  endfunction

  task automatic porCount(input string tag);
    int n;
    n = 0;
    while (sys_reset_o && n < 30) begin
      tick;
      n++;
    end
    chk(tag, n, 8);
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    logic [NS-1:0] h;
    h = hits(a);
    set_wr_en = 1'b1;
    set_wr_addr = a;
    set_wr_data = d;
    tick;
    set_wr_en = 1'b0;
    chk("wr_en", slv_wr_en, h);
    if (h != '0) begin
      chk("wr_data", slv_wr_data, d);
      chk("wr_addr", slv_addr, a);
    end
    if (a == 16'hFFFF) mFlags = '0;
    else if (h == '0) mFlags[1] = 1'b1;
    chk("wr_flags", err_flags, mFlags);
    tick;
    chk("wr_pulse", slv_wr_en, 0);
  endtask

  task automatic doRead(input logic [15:0] a, input int d,
                        input logic [15:0] rdat, input bit ovr);
    logic [NS-1:0] h, ack;
    logic [15:0] e, got;
    int s, lat, expLat;
    h = hits(a);
    s = first(h);
    got = '0;
    set_rd_en = 1'b1;
    set_rd_addr = a;
    tick;
    set_rd_en = 1'b0;
    if (s < 0) begin
      e = (a == 16'hFFFF) ? {13'b0, mFlags} : 16'hDEAD;
      chk("rd_vld1", set_rd_vld, 1);
      chk("rd_data1", set_rd_data, e);
      chk("rd_noacc", slv_rd_en, 0);
      if (a != 16'hFFFF) mFlags[1] = 1'b1;
    end else begin
      chk("rd_en", slv_rd_en, 1 << s);
      chk("rd_addr", slv_addr, a);
      expLat = (d < 16) ? d : 15;
      e = (d < 16) ? rdat : 16'hDEAD;
      lat = -1;
      for (int k = 0; k < 24 && lat < 0; k++) begin
        ack = NS'($urandom);
        ack[s] = (k == d);
        slv_rd_ack = ack;
        slv_rd_data = {$urandom, $urandom};
        slv_rd_data[s*16 +: 16] = rdat;
        if (ovr && k == 1) begin
          set_rd_en = 1'b1;
          set_rd_addr = 16'h0010;
        end
        tick;
        set_rd_en = 1'b0;
        slv_rd_ack = '0;
        if (set_rd_vld) begin
          lat = k;
          got = set_rd_data;
        end
      end
      chk("rd_lat", lat, expLat);
      chk("rd_data", got, e);
      if (ovr) mFlags[2] = 1'b1;
      if (d >= 16) mFlags[0] = 1'b1;
    end
    chk("rd_flags", err_flags, mFlags);
    tick;
    chk("rd_idle", set_rd_vld, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v;
    logic [15:0] a;
    int d;
    bit ovr;
    repeat (3) tick;
    chk("rst_sys", sys_reset_o, 1);
    chk("rst_wr", slv_wr_en, 0);
    chk("rst_rd", slv_rd_en, 0);
    chk("rst_vld", set_rd_vld, 0);
    chk("rst_flags", err_flags, 0);
    chk("rst_addr", slv_addr, 0);
    chk("rst_data", set_rd_data, 0);

    reset_i = 1'b0;
    porCount("por_len");

    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    set_wr_en = 1'b1;
    set_wr_addr = 16'h0102;
    set_rd_en = 1'b1;
    set_rd_addr = 16'h0005;
    tick;
    set_wr_en = 1'b0;
    set_rd_en = 1'b0;
    chk("gate_wr", slv_wr_en, 0);
    chk("gate_rd", slv_rd_en, 0);
    chk("gate_vld", set_rd_vld, 0);
    tick;
    tick;
    chk("por_mid", sys_reset_o, 1);
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    porCount("por_restart");
    tick;
    chk("gate_idle", set_rd_vld, 0);

    doWrite(16'h0102, 16'h1234);
    doRead(16'h0005, 3, 16'hBEEF, 1'b0);
    doRead(16'h0205, 99, 16'h5555, 1'b0);
    doRead(16'hFFFF, 0, 16'h0000, 1'b0);
    doRead(16'h7000, 0, 16'h0000, 1'b0);
    doRead(16'h0105, 5, 16'hA5A5, 1'b1);
    doRead(16'h0301, 15, 16'h0F0F, 1'b0);
    doWrite(16'h0234, 16'hCAFE);
    doWrite(16'hFFFF, 16'h0000);

    set_wr_en = 1'b1;
    set_wr_addr = 16'h0102;
    set_wr_data = 16'h1234;
    set_rd_en = 1'b1;
    set_rd_addr = 16'h0005;
    tick;
    set_wr_en = 1'b0;
    set_rd_en = 1'b0;
    chk("col_wr", slv_wr_en, 4'b0010);
    chk("col_rd", slv_rd_en, 4'b0001);
    chk("col_addr", slv_addr, 16'h0102);
    tick;
    chk("col_addr2", slv_addr, 16'h0005);
    slv_rd_ack = 4'b0001;
    slv_rd_data[15:0] = 16'hBEEF;
    tick;
    slv_rd_ack = '0;
    chk("col_vld", set_rd_vld, 1);
    chk("col_data", set_rd_data, 16'hBEEF);
    tick;

    for (int i = 0; i < 40; i++) begin
      a = randAddr();
      if ($urandom % 5 < 2) begin
        doWrite(a, 16'($urandom));
      end else begin
        d = ($urandom % 4 == 0) ? 99 : int'($urandom % 16);
        ovr = (d >= 2) && ($urandom % 3 == 0);
        doRead(a, d, 16'($urandom), ovr);
      end
    end

    set_rd_en = 1'b1;
    set_rd_addr = 16'h0301;
    tick;
    set_rd_en = 1'b0;
    chk("r6_rd", slv_rd_en, 4'b1000);
    tick;
    reset_i = 1'b1;
    #1;
    mFlags = '0;
    chk("r6_rden", slv_rd_en, 0);
    chk("r6_vld", set_rd_vld, 0);
    chk("r6_sys", sys_reset_o, 1);
    chk("r6_flags", err_flags, mFlags);
    reset_i = 1'b0;
    slv_rd_ack = 4'b1000;
    porCount("r6_por");
    v = 0;
    repeat (4) begin
      tick;
      if (set_rd_vld) v++;
    end
    slv_rd_ack = '0;
    chk("r6_late", v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
